instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 88 ++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a length-prefixed, XOR-checksummed byte stream into instruction RAM
module instr_mem_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);
  localparam logic [2:0] IDLE = 3'd0, LEN_HI = 3'd1, LEN_LO = 3'd2, DATA = 3'd3,
                         CHECK = 3'd4, DONE = 3'd5, ERR = 3'd6;
  logic [2:0] state;
  logic [7:0] len_hi, csum;
  logic [15:0] len, wcnt, n;
  logic [1:0] bcnt;
  logic [23:0] sh;
  logic acc, bad_len;
  always_comb begin
    rx_ready = state == LEN_HI || state == LEN_LO || state == DATA || state == CHECK;
    cpu_hold = rx_ready || state == ERR;
    done = state == DONE;
    error = state == ERR;
    acc = rx_valid && rx_ready;
    n = {len_hi, rx_byte};
    bad_len = n == 16'd0 || 17'(n) > 17'(MAX_WORDS);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      len_hi <= '0;
      len <= '0;
      wcnt <= '0;
      bcnt <= '0;
      csum <= '0;
      sh <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR:
          if (start) begin
            state <= LEN_HI;
            wcnt <= '0;
            bcnt <= '0;
            csum <= '0;
          end
        LEN_HI:
          if (acc) begin
            len_hi <= rx_byte;
            state <= LEN_LO;
          end
        LEN_LO:
          if (acc) begin
            len <= n;
            state <= bad_len ? ERR : DATA;
          end
        DATA:
          if (acc) begin
            csum <= csum ^ rx_byte;
            bcnt <= bcnt + 2'd1;
            sh <= {sh[15:0], rx_byte};
            // Fourth byte of a word: commit it; the final word also ends the data phase
            if (bcnt == 2'd3) begin
              wr_en <= 1'b1;
              wr_data <= {sh, rx_byte};
              wr_addr <= AW'(wcnt);
              wcnt <= wcnt + 16'd1;
              if (wcnt + 16'd1 == len) state <= CHECK;
            end
          end
        CHECK:
          if (acc) state <= rx_byte == csum ? DONE : ERR;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
